mem_req_arbiter: RTL and testbench

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_arb_pkg.sv | 35 +++
 rtl/id_fifo.sv | 74 +++++++
 rtl/mem_req_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the two-master sram-like
//               request arbiter and its in-order id FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

   // Default number of accepted transactions that may await data_ok
   localparam int c_DEFAULT_DEPTH = 4;

   // Master identifier: 0 = data side, 1 = instruction side
   typedef logic master_id_t;

   // Arbiter control states
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,   // no grant held
      ST_LOCK = 1'b1    // grant held until the downstream accepts it
   } arb_state_t;

   // Round-robin pick: on a tie the master that was not granted last wins
   function automatic master_id_t rr_pick(input logic req0,
                                          input logic req1,
                                          input master_id_t last_id);
      if (req0 && req1) begin
         return ~last_id;
      end else if (req1) begin
         return 1'b1;
      end
      return 1'b0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : id_fifo
// Description : Synchronous FIFO of master ids, recording the order in which
//               requests were accepted downstream so responses can be routed.
// Revision    : 1.0 - initial release
// ============================================================================
module id_fifo
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = c_DEFAULT_DEPTH
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  master_id_t               push_id,
   input  logic                     pop,
   output master_id_t               head_id,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

   master_id_t          r_mem [DEPTH];
   logic [c_PTR_W-1:0]  r_wr_ptr;
   logic [c_PTR_W-1:0]  r_rd_ptr;
   logic [c_CNT_W-1:0]  r_count;

   logic                w_do_push;
   logic                w_do_pop;

   // Ignore pushes into a full FIFO and pops from an empty one
   assign w_do_push = push & ~full;
   assign w_do_pop  = pop  & ~empty;

   assign full    = (r_count == c_DEPTH_CNT);
   assign empty   = (r_count == '0);
   assign count   = r_count;
   assign head_id = r_mem[r_rd_ptr];

   // Storage write; entries need no reset since pointers gate validity
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= push_id;
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally (power-of-two DEPTH)
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_arbiter
// Description : Round-robin arbiter merging a data-side and an
//               instruction-side sram-like master onto one downstream port,
//               with in-order response routing and orphan-response detection.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DEPTH  = c_DEFAULT_DEPTH,
   parameter int ADDR_W = 32
)(
   input  logic              clk,
   input  logic              reset,
   // master 0 (data side)
   input  logic              m0_req,
   input  logic              m0_wr,
   input  logic [2:0]        m0_size,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [ADDR_W-1:0] m0_wdata,
   output logic [ADDR_W-1:0] m0_rdata,
   output logic              m0_addr_ok,
   output logic              m0_data_ok,
   // master 1 (instruction side)
   input  logic              m1_req,
   input  logic              m1_wr,
   input  logic [2:0]        m1_size,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [ADDR_W-1:0] m1_wdata,
   output logic [ADDR_W-1:0] m1_rdata,
   output logic              m1_addr_ok,
   output logic              m1_data_ok,
   // shared downstream
   output logic              s_req,
   output logic              s_wr,
   output logic [2:0]        s_size,
   output logic [ADDR_W-1:0] s_addr,
   output logic [ADDR_W-1:0] s_wdata,
   input  logic [ADDR_W-1:0] s_rdata,
   input  logic              s_addr_ok,
   input  logic              s_data_ok,
   // status
   output logic              err_orphan
);

   localparam int c_CNT_W = $clog2(DEPTH) + 1;
   localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

   arb_state_t          r_state;
   master_id_t          r_lock_id;
   master_id_t          r_last_id;
   logic                r_err_orphan;

   master_id_t          w_pick;
   master_id_t          w_gid;
   logic                w_blocked;
   logic                w_grant_valid;
   logic                w_gid_req;
   logic                w_s_req;
   logic                w_hs;
   logic                w_push;
   logic                w_pop;
   logic                w_orphan;
   master_id_t          w_head_id;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic [c_CNT_W-1:0]  w_fifo_count;

   // Grant selection: a held grant wins, otherwise round-robin among requesters
   always_comb begin
      w_pick        = rr_pick(m0_req, m1_req, r_last_id);
      w_blocked     = (w_fifo_count == c_DEPTH_CNT);
      w_gid         = (r_state == ST_LOCK) ? r_lock_id : w_pick;
      w_grant_valid = ~reset & ((r_state == ST_LOCK) | ((m0_req | m1_req) & ~w_blocked));
      w_gid_req     = w_gid ? m1_req : m0_req;
      // A held grant whose master dropped req, or a full FIFO, keeps s_req low
      w_s_req       = w_grant_valid & w_gid_req & ~w_blocked;
      w_hs          = w_s_req & s_addr_ok;
      w_push        = w_hs & ~w_fifo_full;
      w_pop         = ~reset & s_data_ok & ~w_fifo_empty;
      w_orphan      = ~reset & s_data_ok & w_fifo_empty;
   end

   // Downstream request mux from the granted master
   always_comb begin
      s_req   = w_s_req;
      s_wr    = 1'b0;
      s_size  = '0;
      s_addr  = '0;
      s_wdata = '0;
      if (w_grant_valid) begin
         s_wr    = w_gid ? m1_wr    : m0_wr;
         s_size  = w_gid ? m1_size  : m0_size;
         s_addr  = w_gid ? m1_addr  : m0_addr;
         s_wdata = w_gid ? m1_wdata : m0_wdata;
      end
   end

   // Per-master handshake and response routing
   always_comb begin
      m0_addr_ok = w_hs & (w_gid == 1'b0);
      m1_addr_ok = w_hs & (w_gid == 1'b1);
      m0_data_ok = w_pop & (w_head_id == 1'b0);
      m1_data_ok = w_pop & (w_head_id == 1'b1);
      m0_rdata   = s_rdata;
      m1_rdata   = s_rdata;
      err_orphan = r_err_orphan & ~reset;
   end

   // Grant hold / round-robin history / sticky orphan flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_lock_id    <= 1'b0;
         r_last_id    <= 1'b1;
         r_err_orphan <= 1'b0;
      end else begin
         if (w_orphan) begin
            r_err_orphan <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_grant_valid) begin
                  if (w_hs) begin
                     r_last_id <= w_gid;
                  end else begin
                     r_state   <= ST_LOCK;
                     r_lock_id <= w_gid;
                  end
               end
            end
            ST_LOCK: begin
               if (w_hs) begin
                  r_state   <= ST_IDLE;
                  r_last_id <= w_gid;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Order of accepted requests, used to route in-order responses
   id_fifo #(
      .DEPTH   (DEPTH)
   ) u_id_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (w_push),
      .push_id (w_gid),
      .pop     (w_pop),
      .head_id (w_head_id),
      .full    (w_fifo_full),
      .empty   (w_fifo_empty),
      .count   (w_fifo_count)
   );

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_req_arbiter
// Description : Directed bench for mem_req_arbiter with a queue-based
//               reference model compared every cycle plus literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_arbiter;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_wr, m1_req, m1_wr;
   logic [2:0]  m0_size, m1_size, s_size;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
   logic        s_req, s_wr;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic        s_addr_ok, s_data_ok;
   logic        err_orphan;

   int checks = 0;
   int errors = 0;

   mem_req_arbiter #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok),
      .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_rdata(s_rdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
      .err_orphan(err_orphan)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int   mq[$];            // ids of accepted transactions, oldest first
   logic pend_valid = 1'b0;
   int   pend_id    = 0;
   int   last       = 1;
   logic orphan     = 1'b0;

   logic have_grant, exp_s_req, exp_m0_aok, exp_m1_aok, exp_m0_dok, exp_m1_dok, exp_err;
   int   exp_gid;

   task model_eval();
      logic full;
      full       = (mq.size() == DEPTH);
      have_grant = 1'b0;
      exp_gid    = 0;
      exp_s_req  = 1'b0;
      if (!reset) begin
         if (pend_valid) begin
            have_grant = 1'b1;
            exp_gid    = pend_id;
         end else if ((m0_req || m1_req) && !full) begin
            have_grant = 1'b1;
            if (m0_req && m1_req) exp_gid = 1 - last;
            else                  exp_gid = m0_req ? 0 : 1;
         end
         exp_s_req = have_grant && !full && ((exp_gid == 1) ? m1_req : m0_req);
      end
      exp_m0_aok = exp_s_req && s_addr_ok && (exp_gid == 0);
      exp_m1_aok = exp_s_req && s_addr_ok && (exp_gid == 1);
      exp_m0_dok = !reset && s_data_ok && (mq.size() > 0) && (mq[0] == 0);
      exp_m1_dok = !reset && s_data_ok && (mq.size() > 0) && (mq[0] == 1);
      exp_err    = !reset && orphan;
   endtask

   always @(posedge clk) begin
      model_eval();
      if (reset) begin
         mq.delete();
         pend_valid = 1'b0;
         last       = 1;
         orphan     = 1'b0;
      end else begin
         if (s_data_ok) begin
            if (mq.size() > 0) void'(mq.pop_front());
            else               orphan = 1'b1;
         end
         if (have_grant) begin
            if (exp_s_req && s_addr_ok) begin
               mq.push_back(exp_gid);
               last       = exp_gid;
               pend_valid = 1'b0;
            end else begin
               pend_valid = 1'b1;
               pend_id    = exp_gid;
            end
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      model_eval();
      chk("s_req", {31'd0, s_req}, {31'd0, exp_s_req});
      if (exp_s_req) begin
         chk("s_addr",  s_addr,  (exp_gid == 1) ? m1_addr  : m0_addr);
         chk("s_wdata", s_wdata, (exp_gid == 1) ? m1_wdata : m0_wdata);
         chk("s_wr",    {31'd0, s_wr}, {31'd0, (exp_gid == 1) ? m1_wr : m0_wr});
         chk("s_size",  {29'd0, s_size}, {29'd0, (exp_gid == 1) ? m1_size : m0_size});
      end
      chk("m0_addr_ok", {31'd0, m0_addr_ok}, {31'd0, exp_m0_aok});
      chk("m1_addr_ok", {31'd0, m1_addr_ok}, {31'd0, exp_m1_aok});
      chk("m0_data_ok", {31'd0, m0_data_ok}, {31'd0, exp_m0_dok});
      chk("m1_data_ok", {31'd0, m1_data_ok}, {31'd0, exp_m1_dok});
      chk("err_orphan", {31'd0, err_orphan}, {31'd0, exp_err});
      chk("m0_rdata", m0_rdata, s_rdata);
      chk("m1_rdata", m1_rdata, s_rdata);
   end

   // ---------------- directed stimulus with literal expectations ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      m0_req = 1'b0; m1_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      idle_in();
      m0_wr = 1'b0; m1_wr = 1'b0; m0_size = 3'd2; m1_size = 3'd2;
      m0_addr = 32'h1000; m1_addr = 32'h0; m0_wdata = 32'h0; m1_wdata = 32'h0;
      s_rdata = 32'h12345678;
      m0_req  = 1'b1;
      // reset: outputs quiet, rdata passes through
      @(negedge clk);
      chk("rst_s_req", {31'd0, s_req}, 32'd0);
      chk("rst_rdata", m1_rdata, 32'h12345678);
      chk("rst_err", {31'd0, err_orphan}, 32'd0);
      next_cycle();
      next_cycle();

      // single m0 read with late response
      reset = 1'b0; m0_req = 1'b1; s_addr_ok = 1'b1;
      @(negedge clk);
      chk("A_m0_aok", {31'd0, m0_addr_ok}, 32'd1);
      chk("A_s_addr", s_addr, 32'h1000);
      next_cycle();
      idle_in();
      next_cycle();
      next_cycle();
      s_data_ok = 1'b1; s_rdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("A_m0_dok", {31'd0, m0_data_ok}, 32'd1);
      chk("A_m1_dok", {31'd0, m1_data_ok}, 32'd0);
      chk("A_m0_rdata", m0_rdata, 32'hDEADBEEF);
      next_cycle();

      // both masters every cycle: alternate, m1 first since m0 was last
      idle_in();
      m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 32'h2000; m0_wdata = 32'hAAAA0000;
      m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 32'h3000; m1_size = 3'd1;
      s_addr_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("B_m1_aok", {31'd0, m1_addr_ok}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("B_m0_aok", {31'd0, m0_addr_ok}, (i % 2 == 1) ? 32'd1 : 32'd0);
         next_cycle();
      end
      @(negedge clk);
      chk("B_full_block", {31'd0, s_req}, 32'd0);
      next_cycle();
      idle_in();
      s_data_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_rdata = 32'h100 + i;
         @(negedge clk);
         chk("B_m1_dok", {31'd0, m1_data_ok}, (i % 2 == 0) ? 32'd1 : 32'd0);
         next_cycle();
      end

      // m1 held in LOCK while s_addr_ok is late and m0 competes
      idle_in();
      m1_req = 1'b1; m1_addr = 32'h4000; m0_addr = 32'h5000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("C_s_addr_hold", s_addr, 32'h4000);
         next_cycle();
         m0_req = 1'b1;
      end
      s_addr_ok = 1'b1;
      @(negedge clk);
      chk("C_m1_aok", {31'd0, m1_addr_ok}, 32'd1);
      next_cycle();
      m1_req = 1'b0;
      @(negedge clk);
      chk("C_m0_aok", {31'd0, m0_addr_ok}, 32'd1);
      chk("C_s_addr_m0", s_addr, 32'h5000);
      next_cycle();
      idle_in();
      s_data_ok = 1'b1;
      @(negedge clk);
      chk("C_m1_dok", {31'd0, m1_data_ok}, 32'd1);
      next_cycle();
      @(negedge clk);
      chk("C_m0_dok", {31'd0, m0_data_ok}, 32'd1);
      next_cycle();

      // locked master drops req: grant held, s_req low
      idle_in();
      m0_req = 1'b1;
      next_cycle();
      m0_req = 1'b0; m1_req = 1'b1; s_addr_ok = 1'b1;
      @(negedge clk);
      chk("D_drop_s_req", {31'd0, s_req}, 32'd0);
      chk("D_m1_aok", {31'd0, m1_addr_ok}, 32'd0);
      next_cycle();
      m0_req = 1'b1;
      @(negedge clk);
      chk("D_m0_aok", {31'd0, m0_addr_ok}, 32'd1);
      next_cycle();
      idle_in();
      s_data_ok = 1'b1;
      next_cycle();

      // fill to DEPTH, then a fifth request waits for a free slot
      idle_in();
      m1_req = 1'b1; m1_addr = 32'h6000; s_addr_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("E_fill_aok", {31'd0, m1_addr_ok}, 32'd1);
         next_cycle();
      end
      m1_req = 1'b0; m0_req = 1'b1; m0_addr = 32'h7000;
      @(negedge clk);
      chk("E_full_s_req", {31'd0, s_req}, 32'd0);
      next_cycle();
      s_data_ok = 1'b1;
      @(negedge clk);
      chk("E_pop_s_req", {31'd0, s_req}, 32'd0);
      chk("E_pop_m1_dok", {31'd0, m1_data_ok}, 32'd1);
      next_cycle();
      s_data_ok = 1'b0;
      @(negedge clk);
      chk("E_fifth_aok", {31'd0, m0_addr_ok}, 32'd1);
      chk("E_fifth_addr", s_addr, 32'h7000);
      next_cycle();
      idle_in();
      s_data_ok = 1'b1;
      repeat (4) next_cycle();

      // orphan response with nothing outstanding
      idle_in();
      s_data_ok = 1'b1;
      @(negedge clk);
      chk("F_m0_dok", {31'd0, m0_data_ok}, 32'd0);
      chk("F_m1_dok", {31'd0, m1_data_ok}, 32'd0);
      next_cycle();
      s_data_ok = 1'b0;
      @(negedge clk);
      chk("F_err_set", {31'd0, err_orphan}, 32'd1);
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("F_err_sticky", {31'd0, err_orphan}, 32'd1);

      // reset clears; first tie after reset goes to m0; reset with 3 outstanding
      next_cycle();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      m0_req = 1'b1; m1_req = 1'b1; s_addr_ok = 1'b1;
      @(negedge clk);
      chk("G_err_clear", {31'd0, err_orphan}, 32'd0);
      chk("G_tie_m0", {31'd0, m0_addr_ok}, 32'd1);
      next_cycle();
      @(negedge clk);
      chk("G_then_m1", {31'd0, m1_addr_ok}, 32'd1);
      next_cycle();
      next_cycle();
      idle_in();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0; s_data_ok = 1'b1;
      @(negedge clk);
      chk("G_discard_m0", {31'd0, m0_data_ok}, 32'd0);
      chk("G_discard_m1", {31'd0, m1_data_ok}, 32'd0);
      next_cycle();
      s_data_ok = 1'b0;
      @(negedge clk);
      chk("G_orphan", {31'd0, err_orphan}, 32'd1);
      next_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
